// File: rtl/sdram_aref_sched.sv
// SDRAM auto-refresh scheduler: tracks postponed refreshes as debt, raises normal/urgent
// requests, and on grant issues precharge-all plus a burst of auto-refresh commands.
module sdram_aref_sched #(
  parameter int CLK_PER_REF = 750,
  parameter int REF_BURST   = 2,
  parameter int TRP_CLK     = 2,
  parameter int TRC_CLK     = 7,
  parameter int MAX_DEBT    = 8,
  parameter int URGENT_TH   = 6,
  parameter int ADDR_W      = 13,
  parameter int BA_W        = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic              aref_en,
  output logic              aref_req,
  output logic              aref_urgent,
  output logic [3:0]        aref_cmd,
  output logic [BA_W-1:0]   aref_ba,
  output logic [ADDR_W-1:0] aref_addr,
  output logic              aref_end,
  output logic              aref_busy,
  output logic [3:0]        ref_debt,
  output logic              aref_err
);

  localparam int CNT_W    = (CLK_PER_REF > 1) ? $clog2(CLK_PER_REF) : 1;
  localparam int WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int BURST_W  = $clog2(REF_BURST + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_PER_REF - 1);
  localparam logic [WAIT_W-1:0]  TRP_LAST = WAIT_W'(TRP_CLK - 1);
  localparam logic [WAIT_W-1:0]  TRC_LAST = WAIT_W'(TRC_CLK - 1);
  localparam logic [BURST_W-1:0] BURST_N  = BURST_W'(REF_BURST);
  localparam logic [3:0]         DEBT_MAX = 4'(MAX_DEBT);
  localparam logic [3:0]         DEBT_URG = 4'(URGENT_TH);

  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {S_IDLE, S_PCHA, S_TRP, S_AREF, S_TRC, S_END} state_t;

  state_t               state;
  logic [CNT_W-1:0]     ref_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 tick;

  assign tick      = init_end && (ref_cnt == CNT_LAST);
  assign aref_ba   = '1;
  assign aref_addr = '1;

  always_comb begin
    aref_req    = (state == S_IDLE) && (ref_debt != '0) && init_end;
    aref_urgent = (ref_debt >= DEBT_URG);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ref_cnt <= '0;
    end else if (!init_end || tick) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // A tick and a completion in the same cycle cancel; saturation only flags when unpaid.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      ref_debt <= '0;
      aref_err <= 1'b0;
    end else if (tick && !aref_end) begin
      if (ref_debt == DEBT_MAX) aref_err <= 1'b1;
      else                      ref_debt <= ref_debt + 4'd1;
    end else if (!tick && aref_end && (ref_debt != '0)) begin
      ref_debt <= ref_debt - 4'd1;
    end
  end

  // Command/end/busy are registered on the same edge as the state they belong to,
  // so PRE appears in the cycle right after the grant is sampled.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      aref_cmd  <= CMD_NOP;
      aref_end  <= 1'b0;
      aref_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          burst_cnt <= '0;
          wait_cnt  <= '0;
          if (aref_req && aref_en) begin
            state     <= S_PCHA;
            aref_cmd  <= CMD_PRE;
            aref_busy <= 1'b1;
          end
        end
        S_PCHA: begin
          state    <= S_TRP;
          wait_cnt <= '0;
          aref_cmd <= CMD_NOP;
        end
        S_TRP: begin
          if (wait_cnt == TRP_LAST) begin
            state     <= S_AREF;
            aref_cmd  <= CMD_REF;
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_AREF: begin
          state    <= S_TRC;
          wait_cnt <= '0;
          aref_cmd <= CMD_NOP;
        end
        S_TRC: begin
          if (wait_cnt == TRC_LAST) begin
            wait_cnt <= '0;
            if (burst_cnt < BURST_N) begin
              state     <= S_AREF;
              aref_cmd  <= CMD_REF;
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              state    <= S_END;
              aref_end <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_END: begin
          state     <= S_IDLE;
          wait_cnt  <= '0;
          burst_cnt <= '0;
          aref_end  <= 1'b0;
          aref_busy <= 1'b0;
          aref_cmd  <= CMD_NOP;
        end
        default: begin
          state     <= S_IDLE;
          aref_cmd  <= CMD_NOP;
          aref_end  <= 1'b0;
          aref_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
